// File: rtl/adc_sample_frontend.sv
// adc_sample_frontend
// Serial ADC front end for the FIR filter cores. A free-running sample counter
// starts one 16-bit SPI-style frame per sample period (CPOL=1, data captured on
// sclk rising edges), checks the four leading zeros, converts the 12-bit
// offset-binary code to two's complement and raises the f_s strobe one cycle
// after the new word has been published on dout.
module adc_sample_frontend #(
  parameter int CLK_DIV   = 2500,
  parameter int SCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        f_s,
  output logic [11:0] dout,
  output logic        dout_valid,
  output logic        fmt_err
);

  localparam int CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int FS_HIGH = CLK_DIV / 2;
  localparam int FS_W    = (FS_HIGH > 2) ? $clog2(FS_HIGH) : 1;
  localparam int TICK_W  = $clog2(SCLK_HALF + 1);

  // A frame plus its setup/teardown must fit inside the f_s high phase, so a
  // new frame never starts while the previous one is still in flight.
  if ((CLK_DIV % 2) != 0) begin : g_div_odd
    $error("adc_sample_frontend: CLK_DIV must be even");
  end
  if (SCLK_HALF < 1) begin : g_half_zero
    $error("adc_sample_frontend: SCLK_HALF must be at least 1");
  end
  if (!((2 + 32 * SCLK_HALF + 2) < (CLK_DIV / 2))) begin : g_div_short
    $error("adc_sample_frontend: CLK_DIV too short for one ADC frame");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    sample_cnt;
  logic [TICK_W-1:0]   tick;
  logic [4:0]          half_cnt;
  logic [15:0]         shift_reg;
  logic [FS_W-1:0]     fs_cnt;

  // Sample-period counter: wraps every CLK_DIV cycles whether or not en is set,
  // so the sample grid stays fixed while the front end is paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (sample_cnt == CNT_W'(CLK_DIV - 1)) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Frame sequencer: chip select, serial clock, bit capture and publication of
  // the converted word, all from registers so the ADC pins never glitch.
  // SETUP runs one cycle longer than a half period: the first cycle is the
  // chip-select lead time, the rest is the sclk-high idle before the first
  // falling edge. The last sclk high half is kept whole before releasing cs_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      tick       <= '0;
      half_cnt   <= '0;
      shift_reg  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      fmt_err    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      fmt_err    <= 1'b0;
      case (state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          if (sample_cnt == '0 && en) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            tick     <= '0;
          end
        end
        SETUP: begin
          if (tick == TICK_W'(SCLK_HALF)) begin
            state    <= SHIFT;
            adc_sclk <= 1'b0;
            tick     <= '0;
            half_cnt <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        SHIFT: begin
          if (tick == TICK_W'(SCLK_HALF - 1)) begin
            tick     <= '0;
            adc_sclk <= ~adc_sclk;
            half_cnt <= half_cnt + 5'd1;
            if (!adc_sclk) begin
              shift_reg <= {shift_reg[14:0], adc_miso};
            end
            if (half_cnt == 5'd31) begin
              state    <= HOLD;
              adc_sclk <= 1'b1;
              adc_cs_n <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        HOLD: begin
          state <= DONE;
        end
        DONE: begin
          if (shift_reg[15:12] == 4'b0000) begin
            dout       <= {~shift_reg[11], shift_reg[10:0]};
            dout_valid <= 1'b1;
          end else begin
            fmt_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
        end
      endcase
    end
  end

  // Sample strobe: rises the cycle after a good word is published and stays
  // high for half a sample period; bad frames never raise it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_s    <= 1'b0;
      fs_cnt <= '0;
    end else if (dout_valid) begin
      f_s    <= 1'b1;
      fs_cnt <= '0;
    end else if (f_s) begin
      if (fs_cnt == FS_W'(FS_HIGH - 1)) begin
        f_s <= 1'b0;
      end else begin
        fs_cnt <= fs_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_frontend.sv
// tb_adc_sample_frontend
// Drives two front ends (default timing and a fast SCLK_HALF=2 / CLK_DIV=400
// build) from behavioural ADC models and checks their frames, conversions and
// strobe timing against expectations computed from the frame rules.
module tb_adc_sample_frontend;

  localparam int DIV[2]  = '{2500, 400};
  localparam int HALF[2] = '{4, 2};

  logic        clk;
  logic        rst0, rst1, en0;
  logic        miso [2];
  logic        sclk [2];
  logic        cs_n [2];
  logic        fs [2];
  logic        valid [2];
  logic        err [2];
  logic [11:0] dout [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] adc_word [2];
  logic [15:0] adc_shift [2];
  int adc_bit [2];
  bit prev_cs [2];
  bit prev_sclk [2];
  bit prev_fs [2];
  int cs_fall_cyc [2];
  int cs_fall_count [2];
  int sclk_rises [2];
  int half_min [2];
  int half_max [2];
  int last_edge [2];
  int valid_cyc [2];
  int valid_count [2];
  int err_cyc [2];
  int err_count [2];
  int fs_rise_cyc [2];
  int fs_rise_count [2];
  int fs_high [2];
  int exp_dout [2];
  int prev_rise [2];
  bit have_prev [2];

  adc_sample_frontend u_dut (
    .clk(clk), .rst(rst0), .en(en0), .adc_miso(miso[0]),
    .adc_sclk(sclk[0]), .adc_cs_n(cs_n[0]), .f_s(fs[0]),
    .dout(dout[0]), .dout_valid(valid[0]), .fmt_err(err[0])
  );

  adc_sample_frontend #(.CLK_DIV(400), .SCLK_HALF(2)) u_fast (
    .clk(clk), .rst(rst1), .en(1'b1), .adc_miso(miso[1]),
    .adc_sclk(sclk[1]), .adc_cs_n(cs_n[1]), .f_s(fs[1]),
    .dout(dout[1]), .dout_valid(valid[1]), .fmt_err(err[1])
  );

  // 10-unit clock and a cycle counter used to timestamp observed events
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Absolute time limit in case a wait ever slips its own bound
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ADC models and event monitor: each ADC presents the next word bit after
  // every sclk falling edge; the monitor timestamps cs_n, sclk, strobe events
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev_cs[i]   <= cs_n[i];
      prev_sclk[i] <= sclk[i];
      prev_fs[i]   <= fs[i];
      if (prev_cs[i] && !cs_n[i]) begin
        cs_fall_cyc[i]   <= cyc;
        cs_fall_count[i] <= cs_fall_count[i] + 1;
        sclk_rises[i]    <= 0;
        half_min[i]      <= 1000000;
        half_max[i]      <= 0;
        last_edge[i]     <= -1;
        adc_bit[i]       <= 15;
        adc_shift[i]     <= adc_word[i];
        miso[i]          <= 1'b0;
      end else if (!cs_n[i] && (prev_sclk[i] != sclk[i])) begin
        if (last_edge[i] >= 0) begin
          if (cyc - last_edge[i] < half_min[i]) half_min[i] <= cyc - last_edge[i];
          if (cyc - last_edge[i] > half_max[i]) half_max[i] <= cyc - last_edge[i];
        end
        last_edge[i] <= cyc;
        if (!sclk[i]) begin
          if (adc_bit[i] >= 0) miso[i] <= adc_shift[i][adc_bit[i]];
          adc_bit[i] <= adc_bit[i] - 1;
        end else begin
          sclk_rises[i] <= sclk_rises[i] + 1;
        end
      end
      if (valid[i] === 1'b1) begin
        valid_cyc[i]   <= cyc;
        valid_count[i] <= valid_count[i] + 1;
      end
      if (err[i] === 1'b1) begin
        err_cyc[i]   <= cyc;
        err_count[i] <= err_count[i] + 1;
      end
      if (!prev_fs[i] && fs[i] === 1'b1) begin
        fs_rise_cyc[i]   <= cyc;
        fs_rise_count[i] <= fs_rise_count[i] + 1;
      end
      if (prev_fs[i] && fs[i] === 1'b0) fs_high[i] <= cyc - fs_rise_cyc[i];
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Cycles from the cs_n falling edge to dout_valid for a given instance
  function automatic int latency(input int i);
    return 3 + 33 * HALF[i];
  endfunction

  // Wait for the next frame to begin on instance i; returns 0 on timeout
  task automatic waitFrame(input int i, input int limit, output bit ok);
    int base;
    int n;
    base = cs_fall_count[i];
    n = 0;
    while (cs_fall_count[i] == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (cs_fall_count[i] != base);
    if (!ok) checkOutput($sformatf("cs_fall_timeout%0d", i), 0, 1);
  endtask

  // Runs one full frame on instance i with the ADC returning word, then checks
  // the frame shape, the converted result and the strobe against the rules
  task automatic applyStimulus(input int i, input logic [15:0] word);
    int base_v, base_e, base_f, t0, lat;
    bit bad, ok;
    bad = (word[15:12] != 4'h0);
    lat = latency(i);
    adc_word[i] = word;
    base_v = valid_count[i];
    base_e = err_count[i];
    base_f = fs_rise_count[i];
    waitFrame(i, DIV[i] + 10, ok);
    if (!ok) return;
    t0 = cs_fall_cyc[i];
    repeat (lat + 15) @(negedge clk);
    checkOutput($sformatf("sclk_rises%0d", i), sclk_rises[i], 16);
    checkOutput($sformatf("sclk_half_min%0d", i), half_min[i], HALF[i]);
    checkOutput($sformatf("sclk_half_max%0d", i), half_max[i], HALF[i]);
    if (!bad) begin
      exp_dout[i] = int'(word[11:0]) - 2048;
      checkOutput($sformatf("valid_pulses%0d", i), valid_count[i] - base_v, 1);
      checkOutput($sformatf("err_pulses%0d", i), err_count[i] - base_e, 0);
      checkOutput($sformatf("valid_latency%0d", i), valid_cyc[i] - t0, lat);
      checkOutput($sformatf("dout_value%0d", i), int'($signed(dout[i])), exp_dout[i]);
      checkOutput($sformatf("fs_rise_latency%0d", i), fs_rise_cyc[i] - t0, lat + 1);
      if (have_prev[i])
        checkOutput($sformatf("fs_period%0d", i), fs_rise_cyc[i] - prev_rise[i], DIV[i]);
      prev_rise[i] = fs_rise_cyc[i];
      have_prev[i] = 1'b1;
      repeat (DIV[i] / 2 + 5) @(negedge clk);
      checkOutput($sformatf("fs_high%0d", i), fs_high[i], DIV[i] / 2);
      checkOutput($sformatf("fs_low_after%0d", i), int'(fs[i]), 0);
    end else begin
      checkOutput($sformatf("err_pulses%0d", i), err_count[i] - base_e, 1);
      checkOutput($sformatf("valid_on_err%0d", i), valid_count[i] - base_v, 0);
      checkOutput($sformatf("err_latency%0d", i), err_cyc[i] - t0, lat);
      checkOutput($sformatf("dout_held%0d", i), int'($signed(dout[i])), exp_dout[i]);
      checkOutput($sformatf("fs_no_rise%0d", i), fs_rise_count[i] - base_f, 0);
      have_prev[i] = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] fixed_words [5];
    logic [15:0] w;
    int t_prev, rel_cyc, base_v, base_cs;
    bit ok;

    fixed_words = '{16'h0800, 16'h0FFF, 16'h0000, 16'h07FF, 16'h4123};
    rst0 = 1'b1;
    rst1 = 1'b1;
    en0  = 1'b1;
    adc_word[0] = 16'h0800;
    adc_word[1] = 16'h0800;
    exp_dout[0] = 0;
    exp_dout[1] = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", int'(cs_n[0]), 1);
    checkOutput("reset_sclk", int'(sclk[0]), 1);
    checkOutput("reset_fs", int'(fs[0]), 0);
    checkOutput("reset_dout", int'(dout[0]), 0);
    checkOutput("reset_valid", int'(valid[0]), 0);
    checkOutput("reset_fmt_err", int'(err[0]), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    $display("[TB] reset released at cycle %0d", cyc);

    fork
      begin
        // Default build: fixed conversion points, a format error, random codes
        for (int k = 0; k < 8; k++) begin
          if (k < 5) w = fixed_words[k];
          else w = {4'h0, 12'($urandom_range(0, 4095))};
          applyStimulus(0, w);
        end

        // Drop en shortly into a frame: it still publishes, then goes quiet
        adc_word[0] = 16'h0A5C;
        base_v = valid_count[0];
        waitFrame(0, DIV[0] + 10, ok);
        t_prev = cs_fall_cyc[0];
        repeat (10) @(negedge clk);
        en0 = 1'b0;
        repeat (latency(0) + 15) @(negedge clk);
        exp_dout[0] = 32'h0A5C - 2048;
        checkOutput("en_drop_valid", valid_count[0] - base_v, 1);
        checkOutput("en_drop_dout", int'($signed(dout[0])), exp_dout[0]);
        repeat (DIV[0] / 2 + 5) @(negedge clk);
        checkOutput("en_drop_fs_high", fs_high[0], DIV[0] / 2);
        base_cs = cs_fall_count[0];
        base_v = valid_count[0];
        repeat (2 * DIV[0]) @(negedge clk);
        checkOutput("en_low_no_frames", cs_fall_count[0] - base_cs, 0);
        checkOutput("en_low_no_valid", valid_count[0] - base_v, 0);
        checkOutput("en_low_fs", int'(fs[0]), 0);
        checkOutput("en_low_dout", int'($signed(dout[0])), exp_dout[0]);

        // Raise en mid-period: the frame waits for the next period boundary
        adc_word[0] = 16'h0321;
        en0 = 1'b1;
        waitFrame(0, DIV[0] + 10, ok);
        checkOutput("en_rise_on_grid", (cs_fall_cyc[0] - t_prev) % DIV[0], 0);

        // Reset in the middle of the shift phase aborts the frame at once
        repeat (50) @(negedge clk);
        #2 rst0 = 1'b1;
        #1;
        checkOutput("midreset_cs_n", int'(cs_n[0]), 1);
        checkOutput("midreset_sclk", int'(sclk[0]), 1);
        checkOutput("midreset_fs", int'(fs[0]), 0);
        checkOutput("midreset_dout", int'(dout[0]), 0);
        adc_word[0] = 16'h0C0D;
        @(negedge clk);
        rst0 = 1'b0;
        rel_cyc = cyc;
        base_v = valid_count[0];
        waitFrame(0, 20, ok);
        checkOutput("post_reset_start", cs_fall_cyc[0] - rel_cyc, 1);
        repeat (latency(0) + 15) @(negedge clk);
        checkOutput("post_reset_valid", valid_count[0] - base_v, 1);
        checkOutput("post_reset_dout", int'($signed(dout[0])), 32'h0C0D - 2048);
        checkOutput("post_reset_rises", sclk_rises[0], 16);
      end
      begin
        // Fast build: random codes with one malformed frame in the middle
        for (int k = 0; k < 10; k++) begin
          if (k == 4) w = {4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))};
          else w = {4'h0, 12'($urandom_range(0, 4095))};
          applyStimulus(1, w);
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
